// File: rtl/slow_timeout_ctrl.sv
// Decides when the accelerator must run at stock speed after slow-class bus accesses.
// Latency: outputs 1 cycle after the deciding edge. Backpressure: none, pure observer of bus cycles.
module slow_timeout_ctrl #(
    parameter int PRESCALE_W = 10
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       SlowActive,
    output logic       ClockGateEn,
    output logic       SlowExpired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    logic                  bact_r;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [PRESCALE_W-1:0] pre;
    logic [PRESCALE_W-1:0] pre_nxt;
    logic                  class_hit;
    logic                  hit;
    logic                  pre_wrap;

    // Selects only matter on the first clock of a bus cycle.
    assign class_hit = |({IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} &
                         {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd});
    assign hit       = BACT & ~bact_r & class_hit;
    assign pre_wrap  = &pre;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pre_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!hit && !BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_COUNT;
                        cnt_nxt   = SlowTimeout;
                    end
                end
            end
            ST_COUNT: begin
                // A new slow hit beats a same-cycle prescaler wrap.
                if (hit) begin
                    state_nxt = ST_HOLD;
                end else begin
                    pre_nxt = pre + 1'b1;
                    if (pre_wrap) begin
                        if (cnt <= 4'd1) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            bact_r      <= 1'b0;
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            pre         <= '0;
            SlowActive  <= 1'b0;
            ClockGateEn <= 1'b0;
            SlowExpired <= 1'b0;
        end else begin
            bact_r      <= BACT;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pre         <= pre_nxt;
            SlowActive  <= (state_nxt != ST_IDLE);
            ClockGateEn <= (state_nxt != ST_IDLE) & SlowClockGate;
            SlowExpired <= (state != ST_IDLE) & (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_slow_timeout_ctrl.sv
// Directed bench for slow_timeout_ctrl; expected outputs are queued per step and popped after each edge.
module tb_slow_timeout_ctrl;

    localparam int PW = 4;
    localparam int W  = 1 << PW;

    logic       clk = 1'b0;
    logic       nPOR;
    logic       BACT;
    logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       SlowActive, ClockGateEn, SlowExpired;

    typedef struct {
        string      tag;
        logic [2:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    slow_timeout_ctrl #(.PRESCALE_W(PW)) dut (
        .CLK(clk), .nPOR(nPOR), .BACT(BACT),
        .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS),
        .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS),
        .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM),
        .SlowSCC(SlowSCC), .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd),
        .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout),
        .SlowActive(SlowActive), .ClockGateEn(ClockGateEn), .SlowExpired(SlowExpired)
    );

    always #5 clk = ~clk;

    // Queue the expectation {SlowActive, ClockGateEn, SlowExpired}, clock once, then check.
    task automatic cyc(input string tag, input logic sa, input logic cge, input logic se);
        exp_t e;
        logic [2:0] obs;
        e.tag = tag;
        e.v   = {sa, cge, se};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e   = sb.pop_front();
        obs = {SlowActive, ClockGateEn, SlowExpired};
        total++;
        assert (obs === e.v) else begin
            bad++;
            $error("FAIL %s: got act/cge/exp=%b want %b", e.tag, obs, e.v);
        end
    endtask

    initial begin
        nPOR = 1'b0; BACT = 1'b0;
        IACKCS = 0; VIACS = 0; IWMCS = 0; SCCCS = 0; SCSICS = 0; SndCS = 0;
        SlowIACK = 0; SlowVIA = 0; SlowIWM = 0; SlowSCC = 0; SlowSCSI = 0; SlowSnd = 0;
        SlowClockGate = 1'b0; SlowTimeout = 4'd0;

        cyc("reset0", 0, 0, 0);
        cyc("reset1", 0, 0, 0);
        nPOR = 1'b1;

        // 1: VIA cycle with every enable off
        BACT = 1; VIACS = 1;
        for (int i = 0; i < 4; i++) cyc("t1_busy", 0, 0, 0);
        BACT = 0; VIACS = 0;
        cyc("t1_after", 0, 0, 0);
        cyc("t1_idle", 0, 0, 0);

        // 2: VIA slow access, timeout 3; mid-count timeout write must not matter
        SlowVIA = 1; SlowTimeout = 4'd3; SlowClockGate = 1;
        BACT = 1; VIACS = 1;
        cyc("t2_hit", 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("t2_hold", 1, 1, 0);
        BACT = 0; VIACS = 0;
        for (int i = 0; i < 3 * W; i++) begin
            if (i == 5) SlowTimeout = 4'd9;
            cyc("t2_count", 1, 1, 0);
        end
        cyc("t2_expire", 0, 0, 1);
        cyc("t2_idle", 0, 0, 0);

        // 3: zero timeout, IWM access
        SlowVIA = 0; SlowIWM = 1; SlowTimeout = 4'd0; SlowClockGate = 0;
        BACT = 1; IWMCS = 1;
        cyc("t3_hit", 1, 0, 0);
        cyc("t3_hold", 1, 0, 0);
        BACT = 0; IWMCS = 0;
        cyc("t3_expire", 0, 0, 1);
        cyc("t3_idle", 0, 0, 0);

        // 4: SCC hit lands exactly on the final wrap
        SlowIWM = 0; SlowSCC = 1; SlowTimeout = 4'd2; SlowClockGate = 1;
        BACT = 1; SCCCS = 1;
        cyc("t4_hit", 1, 1, 0);
        cyc("t4_hold", 1, 1, 0);
        BACT = 0; SCCCS = 0;
        for (int i = 0; i < 2 * W; i++) cyc("t4_count", 1, 1, 0);
        BACT = 1; SCCCS = 1;
        cyc("t4_rehit", 1, 1, 0);
        cyc("t4_rehold", 1, 1, 0);
        BACT = 0; SCCCS = 0;
        // Non-slow VIA access and SCC enable clear during count change nothing.
        for (int i = 0; i < 2 * W; i++) begin
            if (i == 4) begin BACT = 1; VIACS = 1; SlowSCC = 0; end
            if (i == 8) begin BACT = 0; VIACS = 0; end
            cyc("t4_recount", 1, 1, 0);
        end
        cyc("t4_expire", 0, 0, 1);
        cyc("t4_idle", 0, 0, 0);

        // 5: clock gate toggle in HOLD
        SlowVIA = 1; SlowTimeout = 4'd1; SlowClockGate = 1;
        BACT = 1; VIACS = 1;
        cyc("t5_hit", 1, 1, 0);
        SlowClockGate = 0;
        cyc("t5_gate_off", 1, 0, 0);
        SlowClockGate = 1;
        cyc("t5_gate_on", 1, 1, 0);
        BACT = 0; VIACS = 0;
        for (int i = 0; i < W; i++) cyc("t5_count", 1, 1, 0);
        cyc("t5_expire", 0, 0, 1);
        cyc("t5_idle", 0, 0, 0);

        // 6: reset during COUNT, then a normal hit
        BACT = 1; VIACS = 1;
        cyc("t6_hit", 1, 1, 0);
        BACT = 0; VIACS = 0;
        for (int i = 0; i < 5; i++) cyc("t6_count", 1, 1, 0);
        nPOR = 0;
        cyc("t6_rst", 0, 0, 0);
        nPOR = 1;
        cyc("t6_post_rst", 0, 0, 0);
        BACT = 1; VIACS = 1;
        cyc("t6_rehit", 1, 1, 0);
        BACT = 0; VIACS = 0;
        for (int i = 0; i < W; i++) cyc("t6_count2", 1, 1, 0);
        cyc("t6_expire", 0, 0, 1);
        cyc("t6_idle", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
